mem_demux: RTL

Receive-side parser for the 48-bit memory data stream produced by the memory-port multiplexer. Each stream word is decoded by its 4-bit tag: headers open a bunch-crossing (BX) event, and data words are steered to one of 12 destination memory ports through a shared data bus and a one-hot write strobe. The block keeps per-event word counts, checks BX continuity and flags protocol errors. It sits at the far end of the link, in front of the destination memories.

---
 rtl/mem_demux.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/mem_demux.sv
// Receive-side parser for the tagged 48-bit memory stream: opens BX events on headers,
// steers data words to 12 destination ports, counts words per event and flags protocol errors.
module mem_demux #(
    parameter int unsigned NPORT = 12,
    parameter int unsigned CNTW  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [47:0]      stream_in,
    input  logic             stream_valid,
    input  logic             clr_err,
    output logic [43:0]      port_dat,
    output logic [NPORT-1:0] port_wr,
    output logic [2:0]       cur_bx,
    output logic             evt_open,
    output logic             evt_done,
    output logic [2:0]       evt_bx,
    output logic [CNTW-1:0]  evt_words,
    output logic             err_nohdr,
    output logic             err_tag,
    output logic             err_hdr,
    output logic             err_bx
);

    localparam int unsigned DATW  = 44;
    localparam int unsigned TAGW  = 4;
    localparam int unsigned BXW   = 3;
    localparam int unsigned PIDXW = 4;
    localparam logic [CNTW-1:0] CNT_MAX = '1;

    typedef enum logic [0:0] {
        WAIT_HDR = 1'b0,
        IN_EVENT = 1'b1
    } state_t;

    state_t            state, state_nxt;
    logic [CNTW-1:0]   cnt, cnt_nxt;
    logic [DATW-1:0]   port_dat_nxt;
    logic [NPORT-1:0]  port_wr_nxt;
    logic [BXW-1:0]    cur_bx_nxt;
    logic              evt_done_nxt;
    logic [BXW-1:0]    evt_bx_nxt;
    logic [CNTW-1:0]   evt_words_nxt;
    logic              err_nohdr_nxt, err_tag_nxt, err_hdr_nxt, err_bx_nxt;
    logic              set_nohdr, set_tag, set_hdr, set_bx;

    logic [TAGW-1:0]   tag;
    logic [DATW-1:0]   payload;
    logic [BXW-1:0]    hdr_bx;
    logic [40:0]       hdr_rsvd;
    logic              is_hdr, is_data, is_bad;
    logic [PIDXW-1:0]  pidx;

    assign tag      = stream_in[47:44];
    assign payload  = stream_in[43:0];
    assign hdr_bx   = stream_in[2:0];
    assign hdr_rsvd = stream_in[43:3];
    assign evt_open = (state == IN_EVENT);

    // Tag classification; tags B..D skip the illegal A slot, hence the offset of two
    always_comb begin
        is_hdr  = 1'b0;
        is_data = 1'b0;
        is_bad  = 1'b0;
        pidx    = '0;
        case (tag)
            4'h0:             begin end
            4'hA, 4'hE:       is_bad = 1'b1;
            4'hF:             is_hdr = 1'b1;
            4'hB, 4'hC, 4'hD: begin is_data = 1'b1; pidx = PIDXW'(tag - 4'd2); end
            default:          begin is_data = 1'b1; pidx = PIDXW'(tag - 4'd1); end
        endcase
    end

    // Next-state and output computation
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        port_dat_nxt  = port_dat;
        port_wr_nxt   = '0;
        cur_bx_nxt    = cur_bx;
        evt_done_nxt  = 1'b0;
        evt_bx_nxt    = evt_bx;
        evt_words_nxt = evt_words;
        set_nohdr     = 1'b0;
        set_tag       = 1'b0;
        set_hdr       = 1'b0;
        set_bx        = 1'b0;

        if (stream_valid) begin
            if (is_bad) begin
                set_tag = 1'b1;
            end else if (is_hdr) begin
                set_hdr = |hdr_rsvd;
                if (state == IN_EVENT) begin
                    evt_done_nxt  = 1'b1;
                    evt_bx_nxt    = cur_bx;
                    evt_words_nxt = cnt;
                    set_bx        = (hdr_bx != BXW'(cur_bx + 3'd1));
                end
                state_nxt  = IN_EVENT;
                cur_bx_nxt = hdr_bx;
                cnt_nxt    = '0;
            end else if (is_data) begin
                if (state == WAIT_HDR) begin
                    set_nohdr = 1'b1;
                end else begin
                    port_dat_nxt = payload;
                    port_wr_nxt  = NPORT'(1) << pidx;
                    if (cnt != CNT_MAX) begin
                        cnt_nxt = cnt + CNTW'(1);
                    end
                end
            end
        end

        // A new error in the clearing cycle keeps its flag set
        err_nohdr_nxt = (err_nohdr & ~clr_err) | set_nohdr;
        err_tag_nxt   = (err_tag   & ~clr_err) | set_tag;
        err_hdr_nxt   = (err_hdr   & ~clr_err) | set_hdr;
        err_bx_nxt    = (err_bx    & ~clr_err) | set_bx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= WAIT_HDR;
            cnt       <= '0;
            port_dat  <= '0;
            port_wr   <= '0;
            cur_bx    <= '0;
            evt_done  <= 1'b0;
            evt_bx    <= '0;
            evt_words <= '0;
            err_nohdr <= 1'b0;
            err_tag   <= 1'b0;
            err_hdr   <= 1'b0;
            err_bx    <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            port_dat  <= port_dat_nxt;
            port_wr   <= port_wr_nxt;
            cur_bx    <= cur_bx_nxt;
            evt_done  <= evt_done_nxt;
            evt_bx    <= evt_bx_nxt;
            evt_words <= evt_words_nxt;
            err_nohdr <= err_nohdr_nxt;
            err_tag   <= err_tag_nxt;
            err_hdr   <= err_hdr_nxt;
            err_bx    <= err_bx_nxt;
        end
    end

endmodule
